// File: rtl/approx_mult_pkg.sv
// Shared types for the approx multiplier arbiter.
// Optional stats ports: APPROX_MULT_ARB_STATS_EN.
package approx_mult_pkg;

    localparam int MULT_LAT_DEFAULT = 1;
    localparam int N_REQ_MAX        = 8;
    localparam int ARB_ID_W         = $clog2(N_REQ_MAX);

    typedef enum logic [1:0] {
        PM_PER_REQ       = 2'b00,
        PM_FORCE_PRECISE = 2'b01,
        PM_FORCE_APPROX  = 2'b10
    } prec_mode_t;

    // id sized for the largest supported requester count
    typedef struct packed {
        logic                valid;
        logic [ARB_ID_W-1:0] id;
    } inflight_t;

endpackage

// File: rtl/approx_mult_arbiter_if.sv
// Requester-side issue/response bundle for the multiplier arbiter.
// Optional stats ports: APPROX_MULT_ARB_STATS_EN.
interface approx_mult_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_lock;
    logic [N_REQ-1:0]    req_precise;
    logic [N_REQ*32-1:0] req_a;
    logic [N_REQ*32-1:0] req_b;
    logic [N_REQ-1:0]    req_ready;
    logic                rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [63:0]         rsp_product;

    modport master (
        output req_valid, req_lock, req_precise, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_product
    );

    modport slave (
        input  req_valid, req_lock, req_precise, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_product
    );
endinterface

// File: rtl/mult_rr_picker.sv
// Round-robin picker: first request at or above ptr, wrapping.
// Optional stats ports: APPROX_MULT_ARB_STATS_EN (not used here).
module mult_rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [ID_W-1:0]  ptr,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             hit
);
    int              j;
    logic [ID_W-1:0] jj;

    always_comb begin
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        j   = 0;
        jj  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j  = (int'(ptr) + k) % N_REQ;
            jj = ID_W'(j);
            if (!hit && req[jj]) begin
                hit     = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end
endmodule

// File: rtl/approx_mult_arbiter.sv
// Shares one approx multiplier among N_REQ requesters (rr + burst lock).
// Optional stats counters: define APPROX_MULT_ARB_STATS_EN.
module approx_mult_arbiter
    import approx_mult_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MULT_LAT = MULT_LAT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic [1:0]           prec_mode,
    approx_mult_arbiter_if.slave bus,
    output logic [31:0]          mult_a,
    output logic [31:0]          mult_b,
    output logic                 mult_precise_en,
    input  logic [63:0]          mult_product,
    output logic                 busy
`ifdef APPROX_MULT_ARB_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [31:0]          stat_precise_cnt,
    output logic [31:0]          stat_approx_cnt
`endif
);
    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  lock_id;
    logic             lock_vld;
    logic [N_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_hit;
    logic             lock_hit;
    logic [N_REQ-1:0] gnt_oh;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_any;
    logic             xfer;
    logic [ID_W-1:0]  ptr_nxt;
    inflight_t        pipe [MULT_LAT];

    mult_rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .ptr (rr_ptr),
        .req (bus.req_valid),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .hit (pick_hit)
    );

    // A lock owner that drops valid falls straight through to the rr scan
    assign lock_hit = lock_vld & bus.req_valid[lock_id];

    always_comb begin
        gnt_oh  = pick_gnt;
        gnt_idx = pick_idx;
        gnt_any = pick_hit;
        if (lock_hit) begin
            gnt_oh          = '0;
            gnt_oh[lock_id] = 1'b1;
            gnt_idx         = lock_id;
            gnt_any         = 1'b1;
        end
    end

    assign xfer          = clk_en & gnt_any;
    assign bus.req_ready = xfer ? gnt_oh : '0;
    assign ptr_nxt = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        mult_a          = '0;
        mult_b          = '0;
        mult_precise_en = 1'b1;
        if (xfer) begin
            mult_a = bus.req_a[int'(gnt_idx)*32 +: 32];
            mult_b = bus.req_b[int'(gnt_idx)*32 +: 32];
            unique case (1'b1)
                (prec_mode == PM_FORCE_PRECISE): mult_precise_en = 1'b1;
                (prec_mode == PM_FORCE_APPROX):  mult_precise_en = 1'b0;
                default: mult_precise_en = bus.req_precise[gnt_idx];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= '0;
            lock_vld <= 1'b0;
            lock_id  <= '0;
        end else if (clk_en) begin
            if (xfer) begin
                rr_ptr   <= ptr_nxt;
                lock_vld <= bus.req_lock[gnt_idx];
                lock_id  <= gnt_idx;
            end else if (lock_vld && !bus.req_valid[lock_id]) begin
                lock_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < MULT_LAT; k++) pipe[k] <= '0;
        end else if (clk_en) begin
            pipe[0] <= {xfer, ARB_ID_W'(gnt_idx)};
            for (int k = 1; k < MULT_LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign bus.rsp_valid   = pipe[MULT_LAT-1].valid;
    assign bus.rsp_id      = pipe[MULT_LAT-1].id[ID_W-1:0];
    assign bus.rsp_product = bus.rsp_valid ? mult_product : '0;

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < MULT_LAT; k++) busy = busy | pipe[k].valid;
    end

    if (ID_W < ARB_ID_W) begin : g_id_pad
        logic unused_id_hi;
        assign unused_id_hi = ^pipe[MULT_LAT-1].id[ARB_ID_W-1:ID_W];
    end

`ifdef APPROX_MULT_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_precise_cnt <= '0;
            stat_approx_cnt  <= '0;
        end else if (clk_en) begin
            if (stat_clr) begin
                stat_precise_cnt <= '0;
                stat_approx_cnt  <= '0;
            end else if (xfer) begin
                if (mult_precise_en && stat_precise_cnt != 32'hFFFF_FFFF)
                    stat_precise_cnt <= stat_precise_cnt + 32'd1;
                if (!mult_precise_en && stat_approx_cnt != 32'hFFFF_FFFF)
                    stat_approx_cnt <= stat_approx_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
